cam_sccb_config: RTL and testbench
==================================

Name: cam_sccb_config

Overview:
Configures the OV7670 camera after power-up. It walks a register table of {register, value} pairs and issues one SCCB 3-phase write per entry (ID 0x42, sub-address, data). The table selects RGB565 and QQVGA 160x120 output, which the capture/downsampler path expects. The block runs on clk25M alongside the VGA driver, and the top level drives the SIOC/SIOD pins from its outputs.

Parameters:
CLK_FREQ_HZ, 25000000, frequency of clk.
SCCB_FREQ_HZ, 100000, SIOC bit rate.
QDIV, CLK_FREQ_HZ/(4*SCCB_FREQ_HZ), clk cycles per quarter-bit tick; minimum 1 (62 at defaults).
DELAY_MS, 2, wait time inserted by a table DELAY marker.
ROM_AW, 6, table address width (64 entries max).
CAM_ID, 8'h42, SCCB write ID byte.

Ports:
clk  in  1  system clock (clk25M at top level)
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins the table walk from entry 0
sioc  out  1  SCCB clock
siod_o  out  1  SCCB data value
siod_oe  out  1  1 = drive siod_o; 0 = release the line (pull-up makes it high)
busy  out  1  high from an accepted start until DONE
done  out  1  sticky; high after the END marker, cleared by the next accepted start
cfg_idx  out  ROM_AW  index of the table entry currently being processed

Behaviour:
- Reset (rst=0, async): state IDLE; sioc=1, siod_o=1, siod_oe=1, busy=0, done=0, cfg_idx=0; all counters cleared.
- Reset mid-transaction: bus returns to idle-high at once. No STOP is generated.
- Tick: quarter counter counts 0..QDIV-1; tick=1 on terminal count. All bus phases advance only on tick, except FETCH.
- start is accepted only in IDLE or DONE. On acceptance: busy=1, done=0, cfg_idx=0, next state FETCH. start is ignored while busy.
- FETCH (2 clk, not tick-gated):
  - Cycle 1 presents cfg_idx to the ROM; cycle 2 latches the 16-bit entry.
  - Entry 16'hFFFF -> DONE.
  - Entry 16'hFFF0 -> DELAY.
  - Any other entry -> START, with shift bytes {CAM_ID, entry[15:8], entry[7:0]}.
- START (2 quarters): q0 siod_o=0, sioc=1; q1 sioc=0.
- BIT (27 bits, 4 quarters each, MSB first):
  - q0: sioc=0, siod updated.
  - q1, q2: sioc=1.
  - q3: sioc=0.
  - Bits 9, 18, 27 are the don't-care/ACK slots: siod_oe=0 for that bit. The ACK is not sampled.
- STOP (3 quarters): q0 siod_oe=1, siod_o=0, sioc=0; q1 sioc=1; q2 siod_o=1.
- GAP (4 quarters): bus idle-high. Then cfg_idx increments and the next state is FETCH.
- DELAY: count CLK_FREQ_HZ/1000*DELAY_MS clk cycles with the bus idle-high. Then cfg_idx increments and the next state is FETCH.
- DONE: busy=0, done=1, bus idle-high. Stays until start or reset.
- cfg_idx wrap: if cfg_idx reaches 2^ROM_AW-1 without an END marker, that entry is treated as END.
- Throughput: one write entry = 2 clk + 117 quarter ticks. At QDIV=1 this is exactly 119 clk from FETCH entry to the next FETCH entry.
- Outputs change only on the clk rising edge and are registered; sioc, siod_o and siod_oe must be glitch-free.

Decomposition:
- Shared package/include: OPC_END=16'hFFFF, OPC_DELAY=16'hFFF0, state encodings, SCCB phase quarter counts (START=2, BIT=4, STOP=3, GAP=4).
- Sub-module cam_cfg_rom: synchronous-read table, ROM_AW in, 16-bit data out, 1-cycle latency. It holds the OV7670 entries:
  - 0x1280 reset, then DELAY
  - 0x1214 QVGA+RGB
  - 0x40D0 RGB565
  - 0x0C04 / 0x3E1A scaling to 160x120
  - END

Test Plan:
- Reset then idle: rst=0 for 3 clk, then rst=1 with no start for 500 clk -> sioc=1, siod_oe=1, siod_o=1, busy=0, done=0 throughout.
- Single write, QDIV=1, table {0x1280, END}, start pulse:
  - SIOD carries 0x42, 0x12, 0x80 MSB-first, sampled on sioc rising edges.
  - siod_oe=0 during bits 9, 18, 27.
  - done=1 exactly 2+117+2 clk after FETCH entry.
- Spacing, QDIV=1, table {0x40D0, 0x0C04, END} -> the second START falling SIOD edge occurs exactly 119 clk after the first.
- Delay marker, CLK_FREQ_HZ=4000, DELAY_MS=2, table {0xFFF0, 0x3E1A, END} -> bus stays idle 8 clk after FETCH, then the 0x3E1A write is emitted.
- Busy/restart: start pulses again mid-write -> transaction unchanged. start after done=1 -> done clears next clk, cfg_idx=0, and the table repeats.
- Reset mid-BIT: rst=0 during byte 2 -> same clk asynchronously sioc=1, siod_oe=1, siod_o=1, busy=0; after release, no activity until start.

Source files
------------

// File: rtl/cam_sccb_config_pkg.sv
// Shared constants, state encoding and helpers for the OV7670 SCCB configurator.
package cam_sccb_config_pkg;

  // Table markers that are not register writes
  localparam logic [15:0] OPC_END   = 16'hFFFF;
  localparam logic [15:0] OPC_DELAY = 16'hFFF0;

  // Quarter-bit ticks spent in each bus phase
  localparam int Q_START = 2;
  localparam int Q_BIT   = 4;
  localparam int Q_STOP  = 3;
  localparam int Q_GAP   = 4;

  // Three 9-bit SCCB phases: ID, sub-address, data (8 bits + don't-care slot each)
  localparam int FRAME_BITS = 27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_BIT,
    S_STOP,
    S_GAP,
    S_DELAY,
    S_DONE
  } state_t;

  // The ninth bit of every phase is released so the camera may drive it
  function automatic logic is_ack_slot(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// OV7670 register table: RGB565 output scaled down to QQVGA 160x120.
module cam_cfg_rom
  import cam_sccb_config_pkg::*;
#(
  parameter int ROM_AW = 6
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  // Synchronous read, one cycle of latency; unused locations read as END
  always_ff @(posedge clk) begin
    case (addr)
      ROM_AW'(0): data <= 16'h1280;
      ROM_AW'(1): data <= OPC_DELAY;
      ROM_AW'(2): data <= 16'h1214;
      ROM_AW'(3): data <= 16'h40D0;
      ROM_AW'(4): data <= 16'h0C04;
      ROM_AW'(5): data <= 16'h3E1A;
      default:    data <= OPC_END;
    endcase
  end

endmodule

// File: rtl/cam_sccb_config.sv
// Walks the camera register table and emits one SCCB 3-phase write per entry.
module cam_sccb_config
  import cam_sccb_config_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 25000000,
  parameter int         SCCB_FREQ_HZ = 100000,
  parameter int         QDIV         = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ),
  parameter int         DELAY_MS     = 2,
  parameter int         ROM_AW       = 6,
  parameter logic [7:0] CAM_ID       = 8'h42
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sioc,
  output logic              siod_o,
  output logic              siod_oe,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] cfg_idx
);

  localparam int QD      = (QDIV < 1) ? 1 : QDIV;
  localparam int QW      = (QD > 1) ? $clog2(QD) : 1;
  localparam int DLY_RAW = (CLK_FREQ_HZ / 1000) * DELAY_MS;
  localparam int DLY_N   = (DLY_RAW < 1) ? 1 : DLY_RAW;
  localparam int DW      = (DLY_N > 1) ? $clog2(DLY_N) : 1;

  state_t                  state, state_nxt;
  logic [QW-1:0]           qcnt, qcnt_nxt;
  logic [1:0]              qtr, qtr_nxt;
  logic [4:0]              bit_cnt, bit_nxt;
  logic [DW-1:0]           dcnt, dcnt_nxt;
  logic                    fetch_ph, fetch_nxt;
  logic [ROM_AW-1:0]       idx_nxt;
  logic [FRAME_BITS-1:0]   frame, frame_nxt;
  logic [15:0]             rom_q;
  logic                    tick;
  logic                    sioc_d, siod_d, oe_d, busy_d, done_d;

  cam_cfg_rom #(.ROM_AW(ROM_AW)) u_rom (
    .clk  (clk),
    .addr (cfg_idx),
    .data (rom_q)
  );

  // State, counters and the registered bus pins; outputs follow the next state so they never glitch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      dcnt     <= '0;
      fetch_ph <= 1'b0;
      cfg_idx  <= '0;
      frame    <= '0;
      sioc     <= 1'b1;
      siod_o   <= 1'b1;
      siod_oe  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      qcnt     <= qcnt_nxt;
      qtr      <= qtr_nxt;
      bit_cnt  <= bit_nxt;
      dcnt     <= dcnt_nxt;
      fetch_ph <= fetch_nxt;
      cfg_idx  <= idx_nxt;
      frame    <= frame_nxt;
      sioc     <= sioc_d;
      siod_o   <= siod_d;
      siod_oe  <= oe_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Sequencing: table fetch/decode, quarter-tick phase stepping and the DELAY wait
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = '0;
    qtr_nxt   = qtr;
    bit_nxt   = bit_cnt;
    dcnt_nxt  = '0;
    fetch_nxt = 1'b0;
    idx_nxt   = cfg_idx;
    frame_nxt = frame;
    tick      = (qcnt == QW'(QD - 1));

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_FETCH;
          idx_nxt   = '0;
        end
      end
      S_FETCH: begin
        if (!fetch_ph) begin
          fetch_nxt = 1'b1;
        end else begin
          qtr_nxt = '0;
          bit_nxt = '0;
          if ((rom_q == OPC_END) || (cfg_idx == '1)) begin
            state_nxt = S_DONE;
          end else if (rom_q == OPC_DELAY) begin
            state_nxt = S_DELAY;
          end else begin
            state_nxt = S_START;
            frame_nxt = {CAM_ID, 1'b1, rom_q[15:8], 1'b1, rom_q[7:0], 1'b1};
          end
        end
      end
      S_START, S_BIT, S_STOP, S_GAP: begin
        qcnt_nxt = tick ? '0 : qcnt + QW'(1);
        if (tick) begin
          qtr_nxt = qtr + 2'd1;
          case (state)
            S_START: if (qtr == 2'(Q_START - 1)) begin
              qtr_nxt   = '0;
              state_nxt = S_BIT;
            end
            S_BIT: if (qtr == 2'(Q_BIT - 1)) begin
              qtr_nxt = '0;
              if (bit_cnt == 5'(FRAME_BITS - 1)) state_nxt = S_STOP;
              else                               bit_nxt   = bit_cnt + 5'd1;
            end
            S_STOP: if (qtr == 2'(Q_STOP - 1)) begin
              qtr_nxt   = '0;
              state_nxt = S_GAP;
            end
            default: if (qtr == 2'(Q_GAP - 1)) begin
              qtr_nxt   = '0;
              idx_nxt   = cfg_idx + ROM_AW'(1);
              state_nxt = S_FETCH;
            end
          endcase
        end
      end
      S_DELAY: begin
        if (dcnt == DW'(DLY_N - 1)) begin
          idx_nxt   = cfg_idx + ROM_AW'(1);
          state_nxt = S_FETCH;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus pin and status values for the state being entered
  always_comb begin
    sioc_d = 1'b1;
    siod_d = 1'b1;
    oe_d   = 1'b1;
    busy_d = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    done_d = (state_nxt == S_DONE);
    case (state_nxt)
      S_START: begin
        siod_d = 1'b0;
        sioc_d = (qtr_nxt == 2'd0);
      end
      S_BIT: begin
        sioc_d = (qtr_nxt == 2'd1) || (qtr_nxt == 2'd2);
        siod_d = frame_nxt[5'(FRAME_BITS - 1) - bit_nxt];
        oe_d   = !is_ack_slot(bit_nxt);
      end
      S_STOP: begin
        siod_d = (qtr_nxt == 2'd2);
        sioc_d = (qtr_nxt != 2'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cam_sccb_config.sv
// Scoreboard bench: expected SCCB bytes are queued at start, a bus monitor decodes and compares.
module tb_cam_sccb_config;

  localparam int AW       = 6;
  localparam int DONE_LAT = 607;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sioc, siod_o, siod_oe, busy, done;
  logic [AW-1:0] cfg_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];
  int nbits = 27;
  logic [7:0] shreg = 8'h00;
  logic prev_sioc = 1'b1;
  logic prev_line = 1'b1;

  cam_sccb_config #(
    .CLK_FREQ_HZ (4000),
    .SCCB_FREQ_HZ(1000),
    .QDIV        (1),
    .DELAY_MS    (2),
    .ROM_AW      (AW),
    .CAM_ID      (8'h42)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sioc    (sioc),
    .siod_o  (siod_o),
    .siod_oe (siod_oe),
    .busy    (busy),
    .done    (done),
    .cfg_idx (cfg_idx)
  );

  // 10 ns clock and a free-running cycle count
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  function automatic void checkIdle(input string name);
    checkOutput({name, "_sioc"},    32'(sioc),    1);
    checkOutput({name, "_siod_o"},  32'(siod_o),  1);
    checkOutput({name, "_siod_oe"}, 32'(siod_oe), 1);
    checkOutput({name, "_busy"},    32'(busy),    0);
    checkOutput({name, "_done"},    32'(done),    0);
  endfunction

  // Expected byte stream for the whole table, DELAY marker produces no bytes
  function automatic void pushTable();
    logic [15:0] tbl [5] = '{16'h1280, 16'h1214, 16'h40D0, 16'h0C04, 16'h3E1A};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h42);
      exp_q.push_back(tbl[i][15:8]);
      exp_q.push_back(tbl[i][7:0]);
    end
  endfunction

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done_reached"}, 32'(done), 1);
    checkOutput({name, "_done_latency"}, cyc - accept_cyc, DONE_LAT);
    checkOutput({name, "_end_idx"}, 32'(cfg_idx), 6);
    checkOutput({name, "_bytes_left"}, exp_q.size(), 0);
  endtask

  // Bus monitor: START detection, bit capture on SIOC rising, byte compare against the queue
  always @(negedge clk) begin
    logic line;
    line = siod_oe ? siod_o : 1'b1;
    if (!rst) begin
      nbits = 27;
    end else if (sioc && prev_sioc && prev_line && !line) begin
      nbits = 0;
      start_cyc.push_back(cyc);
    end else if (sioc && !prev_sioc && nbits < 27) begin
      if (nbits % 9 == 8) begin
        checkOutput("ack_release", 32'(siod_oe), 0);
      end else begin
        checkOutput("data_drive", 32'(siod_oe), 1);
        shreg = {shreg[6:0], line};
        if (nbits % 9 == 7) begin
          if (exp_q.size() == 0) checkOutput("byte_extra", 32'(shreg), 32'h100);
          else                   checkOutput("sccb_byte", 32'(shreg), 32'(exp_q.pop_front()));
        end
      end
      nbits++;
    end
    prev_sioc = sioc;
    prev_line = line;
  end

  initial begin
    int spacing [4] = '{129, 119, 119, 119};

    // Reset held, then a long idle stretch with no start
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    checkOutput("reset_idx", 32'(cfg_idx), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (500) begin
      @(negedge clk);
      checkIdle("idle");
    end

    // Full table walk with a stray start pulse in the middle of the first write
    pushTable();
    start_cyc.delete();
    applyStimulus();
    checkOutput("run1_busy", 32'(busy), 1);
    checkOutput("run1_idx0", 32'(cfg_idx), 0);
    repeat (60) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("run1");
    checkOutput("run1_start_count", start_cyc.size(), 5);
    if (start_cyc.size() == 5) begin
      checkOutput("first_start_lat", start_cyc[0] - accept_cyc, 2);
      for (int i = 0; i < 4; i++)
        checkOutput("start_spacing", start_cyc[i+1] - start_cyc[i], spacing[i]);
    end
    repeat (5) @(negedge clk);
    checkOutput("done_sticky", 32'(done), 1);
    checkOutput("done_not_busy", 32'(busy), 0);

    // Restart from DONE, then an asynchronous reset in the middle of the second byte
    pushTable();
    applyStimulus();
    checkOutput("restart_done_clr", 32'(done), 0);
    checkOutput("restart_busy", 32'(busy), 1);
    checkOutput("restart_idx", 32'(cfg_idx), 0);
    repeat (50) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    checkIdle("async_reset");
    checkOutput("async_reset_idx", 32'(cfg_idx), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (100) begin
      @(negedge clk);
      checkIdle("post_reset");
    end

    // Recovery: a clean table walk after the reset
    pushTable();
    start_cyc.delete();
    applyStimulus();
    waitDone("run3");
    checkOutput("run3_start_count", start_cyc.size(), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
